fifo_wr_arbiter: RTL

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_arb_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 40 ++++
 rtl/fifo_wr_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM state encoding,
// default sizing constants and a small sizing helper.
package fifo_arb_pkg;

    localparam int NUM_REQ_DEF    = 4;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int MAX_BURST_DEF  = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Width of an index into a requester vector; never narrower than 1 bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the search starts one position after
// rr_ptr and wraps, so the previous owner has the lowest priority.
module rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int PTR_W   = ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant
);

    // One spare bit so rr_ptr + k (k up to NUM_REQ) cannot overflow before the wrap.
    localparam int SH_W = PTR_W + 1;

    logic [SH_W-1:0]  sum;
    logic [PTR_W-1:0] idx;
    logic             found;

    // Walk candidates in priority order and keep the first one that is requesting.
    always_comb begin
        grant = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr} + SH_W'(k);
            if (sum >= SH_W'(NUM_REQ)) begin
                sum = sum - SH_W'(NUM_REQ);
            end
            idx = sum[PTR_W-1:0];
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares one FIFO write port among NUM_REQ requesters. An owner is picked
// round-robin in IDLE and keeps the port for a whole burst (ended by its last
// flag or by the MAX_BURST cap, legal range 1..16); a single IDLE cycle always
// separates consecutive grants. The FIFO full flag only stalls, never preempts.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int MAX_BURST  = MAX_BURST_DEF
) (
    input  logic                          tx_clk,
    input  logic                          tx_rst_n,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic                          fifo_full_i,
    output logic                          wr_en_o,
    output logic [DATA_WIDTH-1:0]         tx_data_o,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          busy_o
);

    localparam int PTR_W = ptr_width(NUM_REQ);
    // Five bits cover beat indices up to 15, the largest legal cap minus one.
    localparam int CNT_W = 5;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    arb_state_t             state;
    logic [NUM_REQ-1:0]     owner;
    logic [PTR_W-1:0]       owner_idx;
    logic [PTR_W-1:0]       rr_ptr;
    logic [CNT_W-1:0]       beat_cnt;

    logic [NUM_REQ-1:0]     arb_grant;
    logic [PTR_W-1:0]       win_idx;
    logic                   in_grant;
    logic                   transfer;
    logic                   last_hit;
    logic                   burst_done;
    logic [DATA_WIDTH-1:0]  owner_data;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .req    (req_valid_i),
        .rr_ptr (rr_ptr),
        .grant  (arb_grant)
    );

    // Encode the one-hot winner so it can become the next round-robin pointer.
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) begin
                win_idx = PTR_W'(i);
            end
        end
    end

    // Handshake and data path; everything is forced quiet while reset is held.
    always_comb begin
        in_grant    = tx_rst_n && (state == GRANT);
        req_ready_o = in_grant ? (owner & {NUM_REQ{~fifo_full_i}}) : '0;
        transfer    = |(req_valid_i & req_ready_o);
        last_hit    = |(req_last_i & owner);
        burst_done  = transfer && (last_hit || (beat_cnt == LAST_BEAT));
        owner_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner[i]) begin
                owner_data = owner_data | req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign wr_en_o   = transfer;
    assign tx_data_o = in_grant ? owner_data : '0;
    assign grant_o   = owner;
    assign busy_o    = (state == GRANT);

    // Arbitration FSM: latch a winner in IDLE, count beats in GRANT, release on burst end.
    always_ff @(posedge tx_clk) begin
        if (!tx_rst_n) begin
            state     <= IDLE;
            owner     <= '0;
            owner_idx <= '0;
            rr_ptr    <= PTR_W'(NUM_REQ - 1);
            beat_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid_i) begin
                        state     <= GRANT;
                        owner     <= arb_grant;
                        owner_idx <= win_idx;
                        beat_cnt  <= '0;
                    end
                end
                GRANT: begin
                    if (burst_done) begin
                        state    <= IDLE;
                        owner    <= '0;
                        rr_ptr   <= owner_idx;
                        beat_cnt <= '0;
                    end else if (transfer) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
